dma_step_sequencer: RTL and testbench
=====================================

# dma_step_sequencer

Sequencer that drives the 3-bit instruction bus of the transfer datapath's instruction decoder. It arbitrates host register accesses against device word requests, runs a block transfer as a load/step sequence, and terminates on word-count-zero, timeout or abort. It sits between the host/device control interface and the decoder's I input; the decoder's CR input is not driven here.

## Interface
- MAX_WAIT, default 255: maximum number of WAIT cycles without DREQ before the transfer times out; legal range 2..65535.
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  request to begin a transfer; sampled only in IDLE
- ABORT  in  1  level; terminates a transfer in progress
- HOST_REQ  in  1  level; host instruction request, held until HOST_GNT
- HOST_OP  in  3  requested instruction code, stable while HOST_REQ is high
- DREQ  in  1  device ready for one word
- WCZ  in  1  word-counter-zero flag from the datapath, registered there
- I  out  3  instruction code to the decoder
- IVAL  out  1  instruction valid; datapath enables are qualified by IVAL
- HOST_GNT  out  1  one-cycle grant pulse
- DACK  out  1  one-cycle device acknowledge, coincident with a step
- BUSY  out  1  high while not IDLE
- DONE  out  1  one-cycle pulse on normal completion
- TOUT  out  1  one-cycle pulse on timeout
- XFER_CNT  out  16  steps issued since the last START

## Operation
- All outputs are registered. Reset values: I=000, IVAL=0, HOST_GNT=0, DACK=0, BUSY=0, DONE=0, TOUT=0, XFER_CNT=0; the state machine resets to IDLE.
- Instruction codes:
  - 000: reload the control register.
  - 001, 010, 011: readbacks.
  - 100: load the counters from the address and word registers.
  - 101: load the address register.
  - 110: load the word register.
  - 111: transfer step.
- States: IDLE, LOAD, WAIT, STEP. I and IVAL are 1-cycle pulses; IVAL=0 in all other cycles, and I holds its last value.
- IDLE:
  - START=1: go to LOAD and clear XFER_CNT. START has priority over HOST_REQ.
  - Otherwise HOST_REQ=1 with HOST_OP in 000..110: issue I=HOST_OP with IVAL=1 and HOST_GNT=1 for one cycle, then return to IDLE.
  - HOST_OP=111: pulse HOST_GNT with IVAL=0. This request is a NOP.
- LOAD: I=100, IVAL=1 for one cycle, then go to WAIT with the timer cleared.
- WAIT, evaluated with this priority:
  1. ABORT: go to IDLE. No DONE is issued.
  2. WCZ=1: go to IDLE and pulse DONE.
  3. DREQ=1: go to STEP.
  4. Timer equals MAX_WAIT-1: go to IDLE and pulse TOUT.
  5. Otherwise increment the timer. A HOST_REQ with HOST_OP in 001..011 is granted here, issuing a readback with IVAL=1. The state stays WAIT and the timer keeps counting.
- A HOST_REQ with HOST_OP of 000 or 100..110 is not granted while BUSY. It is granted in IDLE after the transfer ends.
- STEP: I=111, IVAL=1, DACK=1 for one cycle. XFER_CNT increments, modulo 2^16 (wraps 0xFFFF to 0). Then go to WAIT with the timer cleared. ABORT sampled in STEP is acted on in the following WAIT cycle, so the step completes.
- Zero-length transfer: WCZ high in the first WAIT cycle ends the transfer with DONE and no step.
- START while BUSY is ignored.
- RST_N low mid-transfer returns the block to IDLE with reset values immediately. No DONE or TOUT is issued.

## Timing
- START sampled at edge n: cycle n+1 is LOAD (I=100, IVAL=1, BUSY=1), and cycle n+2 is WAIT.
- DREQ sampled at WAIT edge m: cycle m+1 is STEP (I=111, IVAL=1, DACK=1), and XFER_CNT shows the new value in cycle m+2.
- WCZ is sampled in the WAIT cycle after STEP and reflects the post-step count. It has priority over a DREQ in the same cycle.
- Minimum word period is 2 cycles (STEP, WAIT).
- Termination: the cycle after the terminating WAIT edge has BUSY=0 and DONE or TOUT equal to 1.
- Host grant latency in IDLE is 1 cycle. The grant cycle carries the issued instruction.
- A timeout fires after exactly MAX_WAIT WAIT cycles without DREQ or WCZ.

## Test plan
- Reset, then a host write sequence:
  - Stimulus: HOST_OP=101, then 110, then 000.
  - Required: each shows I equal to the op with IVAL=1 and HOST_GNT=1 one cycle after request, and BUSY stays 0.
- Four-word transfer:
  - Stimulus: START, DREQ held high, WCZ asserted after the 4th step.
  - Required: LOAD, then 4 STEP pulses spaced 2 cycles apart, then XFER_CNT=4, a DONE pulse and BUSY=0.
- Zero-length transfer:
  - Stimulus: WCZ=1 already in the first WAIT cycle.
  - Required: DONE with XFER_CNT=0 and no DACK.
- Timeout:
  - Stimulus: MAX_WAIT=8, START, DREQ held low.
  - Required: TOUT pulses exactly 8 cycles after WAIT entry, and BUSY falls with it.
- Arbitration during a transfer:
  - Stimulus: in WAIT, HOST_OP=010 together with DREQ=1, and separately HOST_OP=110.
  - Required: STEP is issued first, then the readback I=010 is granted in WAIT. The 110 request is held until IDLE.
- Abort and reset:
  - Stimulus: ABORT in WAIT after 2 steps; separately, RST_N low during STEP.
  - Required for ABORT: IDLE next cycle, no DONE, XFER_CNT=2.
  - Required for reset: all outputs at reset values immediately.

Source files
------------

// File: rtl/dma_step_sequencer.sv
// rtl/dma_step_sequencer.sv - block-transfer instruction sequencer driving the datapath decoder I bus
module dma_step_sequencer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_host_req,
    input  logic [2:0]  i_host_op,
    input  logic        i_dreq,
    input  logic        i_wcz,
    output logic [2:0]  o_i,
    output logic        o_ival,
    output logic        o_host_gnt,
    output logic        o_dack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_tout,
    output logic [15:0] o_xfer_cnt
);

    localparam logic [15:0] LP_TIMER_LAST = 16'(MAX_WAIT - 1);
    localparam logic [2:0]  LP_OP_LOAD    = 3'b100;
    localparam logic [2:0]  LP_OP_STEP    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_STEP = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic [15:0] r_xfer_cnt, w_xfer_cnt_nxt;
    logic [2:0]  r_i, w_i_nxt;
    logic        r_ival, w_ival_nxt;
    logic        r_host_gnt, w_host_gnt_nxt;
    logic        r_dack, w_dack_nxt;
    logic        r_busy;
    logic        r_done, w_done_nxt;
    logic        r_tout, w_tout_nxt;
    logic        w_host_new;
    logic        w_readback;

    // A request still high during its own grant cycle must not be granted twice.
    assign w_host_new = i_host_req & ~r_host_gnt;
    assign w_readback = (i_host_op != 3'b000) & ~i_host_op[2];

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_xfer_cnt_nxt = r_xfer_cnt;
        w_i_nxt        = r_i;
        w_ival_nxt     = 1'b0;
        w_host_gnt_nxt = 1'b0;
        w_dack_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_tout_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = S_LOAD;
                    w_xfer_cnt_nxt = 16'd0;
                    w_i_nxt        = LP_OP_LOAD;
                    w_ival_nxt     = 1'b1;
                end else if (w_host_new) begin
                    w_host_gnt_nxt = 1'b1;
                    if (i_host_op != LP_OP_STEP) begin
                        w_i_nxt    = i_host_op;
                        w_ival_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_state_nxt = S_WAIT;
                w_timer_nxt = 16'd0;
            end
            S_WAIT: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (i_wcz) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (i_dreq) begin
                    w_state_nxt = S_STEP;
                    w_i_nxt     = LP_OP_STEP;
                    w_ival_nxt  = 1'b1;
                    w_dack_nxt  = 1'b1;
                end else if (r_timer == LP_TIMER_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_tout_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                    if (w_host_new && w_readback) begin
                        w_host_gnt_nxt = 1'b1;
                        w_i_nxt        = i_host_op;
                        w_ival_nxt     = 1'b1;
                    end
                end
            end
            S_STEP: begin
                w_state_nxt    = S_WAIT;
                w_timer_nxt    = 16'd0;
                w_xfer_cnt_nxt = r_xfer_cnt + 16'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= 16'd0;
            r_xfer_cnt <= 16'd0;
            r_i        <= 3'b000;
            r_ival     <= 1'b0;
            r_host_gnt <= 1'b0;
            r_dack     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tout     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_xfer_cnt <= w_xfer_cnt_nxt;
            r_i        <= w_i_nxt;
            r_ival     <= w_ival_nxt;
            r_host_gnt <= w_host_gnt_nxt;
            r_dack     <= w_dack_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= w_done_nxt;
            r_tout     <= w_tout_nxt;
        end
    end

    assign o_i        = r_i;
    assign o_ival     = r_ival;
    assign o_host_gnt = r_host_gnt;
    assign o_dack     = r_dack;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_tout     = r_tout;
    assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_dma_step_sequencer.sv
// tb/tb_dma_step_sequencer.sv - self-checking bench for dma_step_sequencer
module tb_dma_step_sequencer;

    localparam int unsigned MW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        host_req = 1'b0;
    logic [2:0]  host_op = 3'b000;
    logic        dreq = 1'b0;
    logic        wcz = 1'b0;
    logic [2:0]  o_i;
    logic        o_ival, o_host_gnt, o_dack, o_busy, o_done, o_tout;
    logic [15:0] o_xfer_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  last_i = 3'b000;
    logic [24:0] exp_v;

    dma_step_sequencer #(.MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_host_req(host_req), .i_host_op(host_op), .i_dreq(dreq), .i_wcz(wcz),
        .o_i(o_i), .o_ival(o_ival), .o_host_gnt(o_host_gnt), .o_dack(o_dack),
        .o_busy(o_busy), .o_done(o_done), .o_tout(o_tout), .o_xfer_cnt(o_xfer_cnt)
    );

    always #5 clk = ~clk;

    // Observed/expected vectors: {I, IVAL, HOST_GNT, DACK, BUSY, DONE, TOUT, XFER_CNT}
    function automatic logic [24:0] outs();
        return {o_i, o_ival, o_host_gnt, o_dack, o_busy, o_done, o_tout, o_xfer_cnt};
    endfunction

    function automatic logic [24:0] ev(input logic [2:0] i, input logic [5:0] flags, input int cnt);
        return {i, flags, 16'(cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        exp_v = ev(3'b000, 6'b000000, 0);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL reset: got %h want %h", outs(), exp_v); end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL reset_release: got %h want %h", outs(), exp_v); end
        last_i = 3'b000;
    endtask

    task automatic test_host_writes();
        logic [2:0] ops[3];
        logic [2:0] op;
        logic [2:0] want_i;
        ops[0] = 3'b101; ops[1] = 3'b110; ops[2] = 3'b000;
        for (int n = 0; n < 11; n++) begin
            op = (n < 3) ? ops[n] : 3'($urandom_range(0, 7));
            host_req = 1'b1;
            host_op  = op;
            tick();
            want_i = (op == 3'b111) ? last_i : op;
            exp_v = ev(want_i, {(op != 3'b111), 5'b10000}, 0);
            n_vec++;
            if (outs() !== exp_v) begin n_err++; $display("FAIL host_grant op=%b: got %h want %h", op, outs(), exp_v); end
            last_i = want_i;
            host_req = 1'b0;
            tick();
            exp_v = ev(last_i, 6'b000000, 0);
            n_vec++;
            if (outs() !== exp_v) begin n_err++; $display("FAIL host_after op=%b: got %h want %h", op, outs(), exp_v); end
        end
    endtask

    // Transfer of nwords steps, each preceded by a random number of idle WAIT cycles, ended by WCZ.
    task automatic run_transfer(input int nwords, input int maxgap, input bit dreq_at_end, input string tag);
        int g;
        start = 1'b1;
        tick();
        exp_v = ev(3'b100, 6'b100100, 0);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL %s_load: got %h want %h", tag, outs(), exp_v); end
        last_i = 3'b100;
        start = 1'b0;
        tick();
        exp_v = ev(last_i, 6'b000100, 0);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL %s_wait0: got %h want %h", tag, outs(), exp_v); end
        for (int k = 0; k < nwords; k++) begin
            g = int'($urandom_range(0, maxgap));
            for (int c = 0; c < g; c++) begin
                dreq = 1'b0;
                tick();
                exp_v = ev(last_i, 6'b000100, k);
                n_vec++;
                if (outs() !== exp_v) begin n_err++; $display("FAIL %s_gap: got %h want %h", tag, outs(), exp_v); end
            end
            dreq = 1'b1;
            tick();
            exp_v = ev(3'b111, 6'b101100, k);
            n_vec++;
            if (outs() !== exp_v) begin n_err++; $display("FAIL %s_step%0d: got %h want %h", tag, k, outs(), exp_v); end
            last_i = 3'b111;
            dreq = 1'b0;
            tick();
            exp_v = ev(last_i, 6'b000100, k + 1);
            n_vec++;
            if (outs() !== exp_v) begin n_err++; $display("FAIL %s_post%0d: got %h want %h", tag, k, outs(), exp_v); end
        end
        wcz  = 1'b1;
        dreq = dreq_at_end;
        tick();
        exp_v = ev(last_i, 6'b000010, nwords);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL %s_done: got %h want %h", tag, outs(), exp_v); end
        wcz  = 1'b0;
        dreq = 1'b0;
        tick();
        exp_v = ev(last_i, 6'b000000, nwords);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL %s_idle: got %h want %h", tag, outs(), exp_v); end
    endtask

    task automatic test_timeout(input int pre_steps);
        start = 1'b1;
        tick();
        last_i = 3'b100;
        start = 1'b0;
        tick();
        for (int k = 0; k < pre_steps; k++) begin
            dreq = 1'b1;
            tick();
            last_i = 3'b111;
            dreq = 1'b0;
            tick();
        end
        // WAIT entry cycle; START held here must be ignored while busy.
        for (int c = 1; c <= int'(MW); c++) begin
            start = (c < int'(MW));
            tick();
            exp_v = (c < int'(MW)) ? ev(last_i, 6'b000100, pre_steps) : ev(last_i, 6'b000001, pre_steps);
            n_vec++;
            if (outs() !== exp_v) begin n_err++; $display("FAIL timeout_c%0d: got %h want %h", c, outs(), exp_v); end
        end
        tick();
        exp_v = ev(last_i, 6'b000000, pre_steps);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL timeout_after: got %h want %h", outs(), exp_v); end
    endtask

    task automatic test_arbitration();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        host_req = 1'b1;
        host_op  = 3'b010;
        dreq     = 1'b1;
        tick();
        exp_v = ev(3'b111, 6'b101100, 0);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL arb_step_first: got %h want %h", outs(), exp_v); end
        dreq = 1'b0;
        tick();
        exp_v = ev(3'b111, 6'b000100, 1);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL arb_wait: got %h want %h", outs(), exp_v); end
        tick();
        exp_v = ev(3'b010, 6'b110100, 1);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL arb_readback: got %h want %h", outs(), exp_v); end
        host_req = 1'b0;
        tick();
        host_req = 1'b1;
        host_op  = 3'b110;
        for (int c = 0; c < 3; c++) begin
            tick();
            exp_v = ev(3'b010, 6'b000100, 1);
            n_vec++;
            if (outs() !== exp_v) begin n_err++; $display("FAIL arb_hold%0d: got %h want %h", c, outs(), exp_v); end
        end
        wcz = 1'b1;
        tick();
        exp_v = ev(3'b010, 6'b000010, 1);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL arb_done: got %h want %h", outs(), exp_v); end
        wcz = 1'b0;
        tick();
        exp_v = ev(3'b110, 6'b110000, 1);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL arb_late_grant: got %h want %h", outs(), exp_v); end
        host_req = 1'b0;
        last_i = 3'b110;
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            dreq = 1'b1;
            tick();
            dreq = 1'b0;
            tick();
        end
        abort = 1'b1;
        tick();
        exp_v = ev(3'b111, 6'b000000, 2);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL abort_wait: got %h want %h", outs(), exp_v); end
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dreq = 1'b1;
        tick();
        dreq  = 1'b0;
        abort = 1'b1;
        tick();
        exp_v = ev(3'b111, 6'b000100, 1);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL abort_in_step: got %h want %h", outs(), exp_v); end
        tick();
        exp_v = ev(3'b111, 6'b000000, 1);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL abort_after_step: got %h want %h", outs(), exp_v); end
        abort  = 1'b0;
        last_i = 3'b111;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dreq = 1'b1;
        tick();
        exp_v = ev(3'b111, 6'b101100, 0);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL rst_step: got %h want %h", outs(), exp_v); end
        dreq  = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_v = ev(3'b000, 6'b000000, 0);
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL rst_async: got %h want %h", outs(), exp_v); end
        #2;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (outs() !== exp_v) begin n_err++; $display("FAIL rst_idle: got %h want %h", outs(), exp_v); end
        last_i = 3'b000;
    endtask

    initial begin
        test_reset();
        test_host_writes();
        run_transfer(4, 0, 1'b1, "four_word");
        run_transfer(0, 0, 1'b0, "zero_len");
        test_timeout(0);
        test_timeout(1);
        test_arbitration();
        test_abort();
        test_reset_mid();
        for (int r = 0; r < 12; r++) begin
            run_transfer(int'($urandom_range(0, 5)), int'(MW) - 2, 1'($urandom_range(0, 1)), "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
